// File: rtl/exe_md_pkg.sv
// rtl/exe_md_pkg.sv - encodings shared by the execute stage and its multiply-divide unit
package exe_md_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;
  localparam logic [2:0] MD_RSVD  = 3'd7;

  localparam logic [1:0] RES_ALU  = 2'd0;
  localparam logic [1:0] RES_HI   = 2'd1;
  localparam logic [1:0] RES_LO   = 2'd2;
  localparam logic [1:0] RES_ALU2 = 2'd3;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_MUL   = 2'd1;
  localparam logic [1:0] ST_DIV   = 2'd2;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  function automatic logic is_md_op(input logic [2:0] op);
    return (op != MD_NONE) && (op != MD_RSVD);
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - integer ALU shared by the pipeline execute stages
import exe_md_pkg::*;

module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       ctrl,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (ctrl)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_XOR: y = a ^ b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: y = ~(a | b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - HI/LO multiply-divide unit: latency-MUL_LAT multiplier, radix-2 restoring divider
import exe_md_pkg::*;

module md_unit #(
  parameter int DATA_W  = 32,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [2:0]        md_op,
  input  logic [1:0]        res_sel,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              stall
);

  localparam int CNT_MAX = (DATA_W > MUL_LAT) ? DATA_W : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  logic [1:0]          state;
  logic [CW-1:0]       count;
  logic [DATA_W-1:0]   op_a, op_b, dq, dr, dbm;
  logic                op_signed, neg_q, neg_r, b_zero;

  logic                md_req, accept, sgn_in;
  logic [DATA_W-1:0]   a_mag, b_mag, pa, pb;
  logic [2*DATA_W-1:0] pa_x, pb_x, prod;
  logic                ps;
  logic [DATA_W:0]     r_sh, r_diff;
  logic [DATA_W-1:0]   q_nx, r_nx, q_fin, r_fin;

  assign busy   = (state != ST_IDLE);
  assign md_req = valid && is_md_op(md_op);
  assign stall  = valid && busy && (is_md_op(md_op) || res_sel == RES_HI || res_sel == RES_LO);
  assign accept = md_req && !stall;
  assign sgn_in = (md_op == MD_MULT) || (md_op == MD_DIV);

  assign a_mag = (sgn_in && src_a[DATA_W-1]) ? -src_a : src_a;
  assign b_mag = (sgn_in && src_b[DATA_W-1]) ? -src_b : src_b;

  // Live operands feed the product when MUL_LAT==1 (write on the accept edge).
  assign pa   = (state == ST_IDLE) ? src_a  : op_a;
  assign pb   = (state == ST_IDLE) ? src_b  : op_b;
  assign ps   = (state == ST_IDLE) ? sgn_in : op_signed;
  assign pa_x = ps ? {{DATA_W{pa[DATA_W-1]}}, pa} : {{DATA_W{1'b0}}, pa};
  assign pb_x = ps ? {{DATA_W{pb[DATA_W-1]}}, pb} : {{DATA_W{1'b0}}, pb};
  assign prod = pa_x * pb_x;

  always_comb begin
    r_sh   = {dr, dq[DATA_W-1]};
    r_diff = r_sh - {1'b0, dbm};
    if (!r_diff[DATA_W]) begin
      r_nx = r_diff[DATA_W-1:0];
      q_nx = {dq[DATA_W-2:0], 1'b1};
    end else begin
      r_nx = r_sh[DATA_W-1:0];
      q_nx = {dq[DATA_W-2:0], 1'b0};
    end
    q_fin = neg_q ? -q_nx : q_nx;
    r_fin = neg_r ? -r_nx : r_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      count     <= '0;
      hi        <= '0;
      lo        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      dq        <= '0;
      dr        <= '0;
      dbm       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      b_zero    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          op_a      <= src_a;
          op_b      <= src_b;
          op_signed <= sgn_in;
          case (md_op)
            MD_MULT, MD_MULTU: begin
              if (MUL_LAT == 1) begin
                hi <= prod[2*DATA_W-1:DATA_W];
                lo <= prod[DATA_W-1:0];
              end else begin
                state <= ST_MUL;
                count <= CW'(MUL_LAT - 1);
              end
            end
            MD_DIV, MD_DIVU: begin
              state  <= ST_DIV;
              count  <= CW'(DATA_W - 1);
              dq     <= a_mag;
              dr     <= '0;
              dbm    <= b_mag;
              neg_q  <= sgn_in && (src_a[DATA_W-1] ^ src_b[DATA_W-1]);
              neg_r  <= sgn_in && src_a[DATA_W-1];
              b_zero <= (src_b == '0);
            end
            MD_MTHI: hi <= src_a;
            MD_MTLO: lo <= src_a;
            default: ;
          endcase
        end
        ST_MUL: begin
          if (count == '0) begin
            hi    <= prod[2*DATA_W-1:DATA_W];
            lo    <= prod[DATA_W-1:0];
            state <= ST_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        ST_DIV: begin
          dq <= q_nx;
          dr <= r_nx;
          if (count == '0) begin
            // min / -1 needs no special case: |min| negated wraps back to min.
            lo    <= b_zero ? '1 : q_fin;
            hi    <= b_zero ? op_a : r_fin;
            state <= ST_IDLE;
          end else begin
            count <= count - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage_md.sv
// rtl/exe_stage_md.sv - MIPS execute stage: forwarding muxes, ALU, destination select, HI/LO unit
import exe_md_pkg::*;

module exe_stage_md #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MUL_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidE,
  input  logic [3:0]        ALUControlE,
  input  logic              ALUSrcE,
  input  logic              RegDstE,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] RD1E,
  input  logic [DATA_W-1:0] RD2E,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] RdE,
  input  logic [DATA_W-1:0] SignImmE,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [2:0]        MdOpE,
  input  logic [1:0]        ResSelE,
  output logic [DATA_W-1:0] ALUOutE,
  output logic [DATA_W-1:0] WriteDataE,
  output logic [REG_AW-1:0] WriteRegE,
  output logic              MdBusyE,
  output logic              StallE
);

  logic [DATA_W-1:0] src_a, src_b, alu_y, hi, lo;

  assign src_a      = (ForwardAE == FWD_REG) ? RD1E : (ForwardAE == FWD_WB) ? ResultW : ALUOutM;
  assign WriteDataE = (ForwardBE == FWD_REG) ? RD2E : (ForwardBE == FWD_WB) ? ResultW : ALUOutM;
  assign src_b      = ALUSrcE ? SignImmE : WriteDataE;
  assign WriteRegE  = RegDstE ? RdE : RtE;

  alu #(.WIDTH(DATA_W)) u_alu (
    .a    (src_a),
    .b    (src_b),
    .ctrl (ALUControlE),
    .y    (alu_y)
  );

  md_unit #(.DATA_W(DATA_W), .MUL_LAT(MUL_LAT)) u_md (
    .clk     (clk),
    .rst     (rst),
    .valid   (ValidE),
    .md_op   (MdOpE),
    .res_sel (ResSelE),
    .src_a   (src_a),
    .src_b   (src_b),
    .hi      (hi),
    .lo      (lo),
    .busy    (MdBusyE),
    .stall   (StallE)
  );

  always_comb begin
    case (ResSelE)
      RES_HI:  ALUOutE = hi;
      RES_LO:  ALUOutE = lo;
      default: ALUOutE = alu_y;
    endcase
  end

endmodule

// File: doc/exe_stage_md.md
Name: exe_stage_md

Overview:
Parametrised next-generation execute stage for the 5-stage MIPS pipeline. Keeps the forwarding-mux/ALU/destination-select datapath and adds a HI/LO multiply-divide unit. The unit has a pipelined multiplier and an iterative radix-2 divider. A stall output goes to the hazard unit. Sits between the ID/EX and EX/MEM pipeline registers.

Parameters:
DATA_W, 32, datapath width (even, >=8)
REG_AW, 5, register-index width
MUL_LAT, 3, multiply latency in cycles from issue to HI/LO update (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
ValidE  in  1  instruction in EX is valid (not a bubble)
ALUControlE  in  4  ALU operation code, same encoding as ALU
ALUSrcE  in  1  0: SrcB=forwarded Rt, 1: SignImmE
RegDstE  in  1  0: WriteReg=RtE, 1: RdE
ForwardAE/ForwardBE  in  2 each  00 reg file, 01 ResultW, 10/11 ALUOutM
RD1E, RD2E  in  DATA_W each  register-file operands
RtE, RdE  in  REG_AW each  register indices
SignImmE  in  DATA_W  extended immediate
ResultW, ALUOutM  in  DATA_W each  forwarded values
MdOpE  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none)
ResSelE  in  2  0 ALU, 1 HI (MFHI), 2 LO (MFLO), 3 ALU
ALUOutE  out  DATA_W  selected EX result
WriteDataE  out  DATA_W  forwarded Rt (store data)
WriteRegE  out  REG_AW  destination register
MdBusyE  out  1  multiply/divide in flight
StallE  out  1  hold IF/ID/EX, bubble into MEM

Behaviour:
- Combinational path:
  - SrcA = ForwardAE mux (00 RD1E, 01 ResultW, else ALUOutM).
  - WriteDataE = the same mux on RD2E/ForwardBE.
  - SrcB = ALUSrcE ? SignImmE : WriteDataE.
  - WriteRegE = RegDstE ? RdE : RtE.
  - ALUOutE = ALU result, or HI/LO register per ResSelE.
- StallE = ValidE & MdBusyE & (MdOpE in 1..6 | ResSelE in {1,2}). Purely combinational, no added latency.
- Accept: an MD op is accepted on a rising edge when ValidE=1, MdOpE in 1..6 and StallE=0. Nothing is latched while stalled.
- State machine: IDLE, MUL, DIV.
  - IDLE: MULT/MULTU -> MUL with count=MUL_LAT-1. DIV/DIVU -> DIV with count=DATA_W-1. MTHI/MTLO write HI/LO from SrcA at that edge and stay IDLE.
  - MUL: operands latched at accept; 2*DATA_W-bit product (signed or unsigned). HI/LO take the product upper/lower half on the edge where count==0, then -> IDLE. For MUL_LAT=1 the write happens on the accept edge itself and MUL is never entered.
  - DIV: restoring, one quotient bit per cycle on magnitudes, DATA_W cycles. Sign fixup at the final write.
    - Quotient truncates toward zero; remainder takes the dividend's sign.
    - LO=quotient, HI=remainder, written when count==0, then -> IDLE.
    - Divide by zero: LO=all ones, HI=dividend (raw SrcA). Still takes DATA_W cycles.
    - Signed overflow (min / -1): LO=min, HI=0.
- MdBusyE = (state != IDLE). It deasserts in the cycle after the HI/LO write.
- MFHI/MFLO issued in the first cycle with MdBusyE=0 reads the updated HI/LO.
- Back-to-back MD ops: the second stalls until IDLE, then is accepted.
- Reset: HI=0, LO=0, state=IDLE, counters 0, MdBusyE=0, StallE=0. Reset mid-operation aborts the op; no partial HI/LO write. Combinational outputs follow inputs at all times.

Decomposition:
- Package exe_md_pkg: MdOp encodings, ResSel encodings, forward-select constants, state enumeration.
- One sub-module, md_unit: multiply pipeline, iterative divider, HI/LO registers, FSM.
- The existing ALU is instantiated unchanged at width DATA_W.

Test Plan:
- Forwarding: RD1E=5, ResultW=7, ALUOutM=9, ForwardAE=01, ADD with ALUSrcE=1, SignImmE=3 -> ALUOutE=10. ForwardBE=10 -> WriteDataE=9.
- MULT: SrcA=-3, SrcB=7, MUL_LAT=3 -> MdBusyE high for 3 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFEB. MFLO next cycle -> ALUOutE=0xFFFFFFEB.
- DIV: -7 / 2 -> 32 busy cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- Hazard: MFHI held valid during DIV -> StallE=1 every busy cycle, 0 in the first idle cycle, correct HI returned.
- Back-to-back: MULTU issued while a MULT is busy -> stalled until IDLE, then accepted. MTLO 0x1234 when idle -> LO=0x1234 next cycle.
- Reset mid-DIV at cycle 10 -> MdBusyE=0, HI=LO=0 next cycle, no later write.
